csr_timer_bank: RTL



---
 rtl/csr_timer_pkg.sv | 15 +
 rtl/csr_timer_chan.sv | 78 +++++++
 rtl/csr_timer_bank.sv | 91 +++++++++
 3 files changed

// File: rtl/csr_timer_pkg.sv
// Shared constants for the CSR timer bank: register offsets,
// channel stride and TCFG field positions.
package csr_timer_pkg;

  localparam int TMR_STRIDE = 4;

  localparam int OFF_TCFG  = 0;
  localparam int OFF_TVAL  = 1;
  localparam int OFF_TICLR = 2;
  localparam int OFF_TPRE  = 3;

  localparam int EN_BIT  = 0;
  localparam int PER_BIT = 1;

endpackage

// File: rtl/csr_timer_chan.sv
// One timer channel: config, prescaler, down-counter and
// write-1-to-clear pending bit.
module csr_timer_chan
  import csr_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_we,
  input  logic                 clr_we,
  input  logic                 pre_we,
  input  logic [31:0]          wmask,
  input  logic [31:0]          wvalue,
  output logic [CNT_WIDTH-1:0] cfg_q,
  output logic [CNT_WIDTH-1:0] cnt_q,
  output logic [PRE_WIDTH-1:0] pre_q,
  output logic                 pending
);

  logic [CNT_WIDTH-1:0] cfg_new;
  logic [CNT_WIDTH-1:0] reload;
  logic [PRE_WIDTH-1:0] pre_new;
  logic [PRE_WIDTH-1:0] pre_cnt;
  logic                 active;
  logic                 tick;
  logic                 cnt_zero;
  logic                 expire;
  logic                 clr;

  assign cfg_new = (wmask[CNT_WIDTH-1:0] & wvalue[CNT_WIDTH-1:0])
                 | (~wmask[CNT_WIDTH-1:0] & cfg_q);
  assign pre_new = (wmask[PRE_WIDTH-1:0] & wvalue[PRE_WIDTH-1:0])
                 | (~wmask[PRE_WIDTH-1:0] & pre_q);

  assign reload   = {cfg_q[CNT_WIDTH-1:2], 2'b00};
  // all-ones count is the stopped sentinel
  assign active   = cfg_q[EN_BIT] && !(&cnt_q);
  assign tick     = active && (pre_cnt == pre_q);
  assign cnt_zero = (cnt_q == '0);
  assign expire   = tick && cnt_zero && !cfg_we;
  assign clr      = clr_we && wmask[0] && wvalue[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_q   <= '0;
      cnt_q   <= '1;
      pre_q   <= '0;
      pre_cnt <= '0;
      pending <= 1'b0;
    end else begin
      if (cfg_we) cfg_q <= cfg_new;
      if (pre_we) pre_q <= pre_new;
      if (cfg_we) begin
        if (cfg_new[EN_BIT]) begin
          cnt_q   <= {cfg_new[CNT_WIDTH-1:2], 2'b00};
          pre_cnt <= '0;
        end
      end else if (active) begin
        if (tick) begin
          pre_cnt <= '0;
          if (cnt_zero)
            cnt_q <= cfg_q[PER_BIT] ? reload : '1;
          else
            cnt_q <= cnt_q - 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
      if (pre_we) pre_cnt <= '0;
      // expiry wins over a same-cycle clear
      if (expire)   pending <= 1'b1;
      else if (clr) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_timer_bank.sv
// Timer/interrupt CSR bank: NUM_TIMERS channels, address decode,
// read mux and a 64-bit free-running stable counter.
module csr_timer_bank
  import csr_timer_pkg::*;
#(
  parameter int          NUM_TIMERS = 2,
  parameter int          CNT_WIDTH  = 32,
  parameter int          PRE_WIDTH  = 8,
  parameter logic [13:0] CSR_BASE   = 14'h41
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  output logic [31:0]           csr_rvalue,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic                  any_irq,
  output logic [63:0]           stable_counter_value
);

  logic [31:0] ch_rd [NUM_TIMERS];
  logic [31:0] rd_mux;
  logic [63:0] stable_q;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    localparam logic [13:0] B = CSR_BASE + 14'(TMR_STRIDE * i);

    logic [CNT_WIDTH-1:0] cfg_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [PRE_WIDTH-1:0] pre_q;
    logic                 hit_cfg;
    logic                 hit_val;
    logic                 hit_clr;
    logic                 hit_pre;
    logic [31:0]          rd;

    assign hit_cfg = (csr_num == B + 14'(OFF_TCFG));
    assign hit_val = (csr_num == B + 14'(OFF_TVAL));
    assign hit_clr = (csr_num == B + 14'(OFF_TICLR));
    assign hit_pre = (csr_num == B + 14'(OFF_TPRE));

    csr_timer_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .PRE_WIDTH (PRE_WIDTH)
    ) u_chan (
      .clk     (clk),
      .resetn  (resetn),
      .cfg_we  (csr_we & hit_cfg),
      .clr_we  (csr_we & hit_clr),
      .pre_we  (csr_we & hit_pre),
      .wmask   (csr_wmask),
      .wvalue  (csr_wvalue),
      .cfg_q   (cfg_q),
      .cnt_q   (cnt_q),
      .pre_q   (pre_q),
      .pending (timer_irq[i])
    );

    always_comb begin
      rd = '0;
      unique case (1'b1)
        hit_cfg: rd = 32'(cfg_q);
        hit_val: rd = 32'(cnt_q);
        hit_pre: rd = 32'(pre_q);
        default: rd = '0;
      endcase
    end

    assign ch_rd[i] = rd;
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_TIMERS; k++)
      rd_mux = rd_mux | ch_rd[k];
  end

  assign csr_rvalue = csr_re ? rd_mux : '0;
  assign any_irq    = |timer_irq;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stable_q <= '0;
    else         stable_q <= stable_q + 64'd1;
  end

  assign stable_counter_value = stable_q;

endmodule
